regfile_read_ctrl: RTL and testbench

Read-side controller for the 8-entry × 8-bit general register bank built from `register8bit` instances. It takes the flattened outputs of all registers and serves single-register and 8-register burst reads to a consumer over a valid/ready output. Reads that coincide with a register write to the same address return the newly written value (write bypass). The block sits between the register bank and the datapath or debug readout logic.

---
 rtl/regfile_read_ctrl.sv | 153 +++++++++++++++
 tb/tb_regfile_read_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_ctrl.sv
// regfile_read_ctrl
// Read-side controller for the general register bank. Serves single reads and
// 8-beat wrapping burst reads to a consumer over a valid/ready output stage.
// A read that lands in the same cycle as a write to the same register returns
// the value being written (write bypass), including on burst beats.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   regBank                 flattened register outputs, reg i at [i*WIDTH +: WIDTH]
//   regWrite/wrAddr/wrData  write committing at this edge (used for bypass)
//   rdReq/rdBurst/rdAddr    read request, burst select, start address
//   rdAck                   combinational request accept
//   busy                    burst in progress with beats still to capture
//   outValid/outAddr/outData/outLast/outReady   output beat handshake
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no burst pending; a request may be accepted when the slot is free
// BURST | burst accepted; remaining beats captured as the slot frees up

module regfile_read_ctrl #(
  parameter int NREGS  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] regBank,
  input  logic                   regWrite,
  input  logic [ADDR_W-1:0]      wrAddr,
  input  logic [WIDTH-1:0]       wrData,
  input  logic                   rdReq,
  input  logic                   rdBurst,
  input  logic [ADDR_W-1:0]      rdAddr,
  output logic                   rdAck,
  output logic                   busy,
  output logic                   outValid,
  output logic [ADDR_W-1:0]      outAddr,
  output logic [WIDTH-1:0]       outData,
  output logic                   outLast,
  input  logic                   outReady
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } stateT;

  stateT             state, stateNext;
  logic [ADDR_W-1:0] nextAddr, nextAddrNext;
  logic [ADDR_W-1:0] count, countNext;

  logic              slotFree;
  logic              capture;
  logic [ADDR_W-1:0] capAddr;
  logic [WIDTH-1:0]  capData;
  logic              capLast;

  logic              outValidNext;
  logic [ADDR_W-1:0] outAddrNext;
  logic [WIDTH-1:0]  outDataNext;
  logic              outLastNext;

  logic [WIDTH-1:0]  bankWords [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      bankWords[i] = regBank[i*WIDTH +: WIDTH];
    end
  end

  assign busy = (state == BURST);

  always_comb begin
    slotFree     = !outValid || outReady;
    rdAck        = rdReq && (state == IDLE) && slotFree && !reset;

    capture      = 1'b0;
    capAddr      = rdAddr;
    capLast      = 1'b0;
    stateNext    = state;
    nextAddrNext = nextAddr;
    countNext    = count;

    case (state)
      IDLE: begin
        if (rdAck) begin
          capture = 1'b1;
          capAddr = rdAddr;
          if (rdBurst) begin
            capLast      = 1'b0;
            nextAddrNext = rdAddr + 1'b1;
            countNext    = ADDR_W'(NREGS - 1);
            stateNext    = BURST;
          end else begin
            capLast = 1'b1;
          end
        end
      end
      BURST: begin
        if (slotFree) begin
          capture      = 1'b1;
          capAddr      = nextAddr;
          nextAddrNext = nextAddr + 1'b1;
          countNext    = count - 1'b1;
          // The beat that takes the remaining count to zero ends the burst.
          capLast      = (count == ADDR_W'(1));
          if (count == ADDR_W'(1)) begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    // Bypass: the bank outputs still show the old value during the write cycle.
    capData = (regWrite && (wrAddr == capAddr)) ? wrData : bankWords[capAddr];

    outValidNext = outValid;
    outAddrNext  = outAddr;
    outDataNext  = outData;
    outLastNext  = outLast;
    if (capture) begin
      outValidNext = 1'b1;
      outAddrNext  = capAddr;
      outDataNext  = capData;
      outLastNext  = capLast;
    end else if (outValid && outReady) begin
      outValidNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      nextAddr <= '0;
      count    <= '0;
      outValid <= 1'b0;
      outAddr  <= '0;
      outData  <= '0;
      outLast  <= 1'b0;
    end else begin
      state    <= stateNext;
      nextAddr <= nextAddrNext;
      count    <= countNext;
      outValid <= outValidNext;
      outAddr  <= outAddrNext;
      outData  <= outDataNext;
      outLast  <= outLastNext;
    end
  end

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Testbench for regfile_read_ctrl: directed scenarios plus randomized single
// reads and bursts checked against a beat-list reference model.

module tb_regfile_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] regBank;
  logic        regWrite;
  logic [2:0]  wrAddr;
  logic [7:0]  wrData;
  logic        rdReq;
  logic        rdBurst;
  logic [2:0]  rdAddr;
  logic        rdAck;
  logic        busy;
  logic        outValid;
  logic [2:0]  outAddr;
  logic [7:0]  outData;
  logic        outLast;
  logic        outReady;

  logic [7:0]  bankMem [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) regBank[i*8 +: 8] = bankMem[i];
  end

  regfile_read_ctrl #(.NREGS(8), .WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .regBank(regBank),
    .regWrite(regWrite), .wrAddr(wrAddr), .wrData(wrData),
    .rdReq(rdReq), .rdBurst(rdBurst), .rdAddr(rdAddr), .rdAck(rdAck),
    .busy(busy), .outValid(outValid), .outAddr(outAddr), .outData(outData),
    .outLast(outLast), .outReady(outReady)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clearReq;
    rdReq = 1'b0; rdBurst = 1'b0; rdAddr = 3'd0;
    regWrite = 1'b0; wrAddr = 3'd0; wrData = 8'd0;
  endtask

  task automatic test_reset;
    clearReq();
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) bankMem[i] = 8'($urandom);
    reset = 1'b1;
    rdReq = 1'b1; rdAddr = 3'd3;
    step(); step();
    checks++;
    if ({outValid, outAddr, outData, outLast, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b a=%0d d=%h l=%b busy=%b, want all 0",
               outValid, outAddr, outData, outLast, busy);
    end
    checks++;
    if (rdAck !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", rdAck);
    end
    reset = 1'b0;
    clearReq();
    step();
  endtask

  task automatic test_single;
    bankMem[5] = 8'hA5;
    rdReq = 1'b1; rdAddr = 3'd5; rdBurst = 1'b0; outReady = 1'b1;
    #1;
    checks++;
    if (rdAck !== 1'b1) begin
      errors++; $display("FAIL single_ack: got %b want 1", rdAck);
    end
    step();
    clearReq();
    checks++;
    if ({outValid, outAddr, outData, outLast} !== {1'b1, 3'd5, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_beat: got v=%b a=%0d d=%h l=%b want v=1 a=5 d=a5 l=1",
               outValid, outAddr, outData, outLast);
    end
    step();
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL single_empty: got outValid=%b want 0", outValid);
    end
  endtask

  task automatic test_bypass;
    bankMem[2] = 8'h11;
    outReady = 1'b1;
    rdReq = 1'b1; rdAddr = 3'd2; regWrite = 1'b1; wrAddr = 3'd2; wrData = 8'h3C;
    step();
    clearReq();
    bankMem[2] = 8'h3C;
    checks++;
    if ({outValid, outData} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL bypass_same: got v=%b d=%h want v=1 d=3c", outValid, outData);
    end
    step();
    bankMem[2] = 8'h11;
    rdReq = 1'b1; rdAddr = 3'd2; regWrite = 1'b1; wrAddr = 3'd3; wrData = 8'h3C;
    step();
    clearReq();
    bankMem[3] = 8'h3C;
    checks++;
    if ({outValid, outData} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL bypass_other: got v=%b d=%h want v=1 d=11", outValid, outData);
    end
    step();
    // Write one cycle after the capture must not alter the held beat.
    outReady = 1'b0;
    rdReq = 1'b1; rdAddr = 3'd2;
    step();
    clearReq();
    regWrite = 1'b1; wrAddr = 3'd2; wrData = 8'h77;
    step();
    clearReq();
    bankMem[2] = 8'h77;
    checks++;
    if ({outValid, outAddr, outData} !== {1'b1, 3'd2, 8'h11}) begin
      errors++;
      $display("FAIL bypass_late: got v=%b a=%0d d=%h want v=1 a=2 d=11", outValid, outAddr, outData);
    end
    outReady = 1'b1;
    step();
  endtask

  task automatic test_burst_wrap;
    int busyCycles;
    logic [2:0] ea;
    for (int i = 0; i < 8; i++) bankMem[i] = 8'(8'h10 + i);
    outReady = 1'b1;
    rdReq = 1'b1; rdBurst = 1'b1; rdAddr = 3'd6;
    #1;
    checks++;
    if (rdAck !== 1'b1) begin
      errors++; $display("FAIL burst_ack: got %b want 1", rdAck);
    end
    step();
    clearReq();
    busyCycles = 0;
    for (int k = 0; k < 8; k++) begin
      ea = 3'((6 + k) % 8);
      checks++;
      if ({outValid, outAddr, outData, outLast} !== {1'b1, ea, 8'(8'h10 + ea), (k == 7)}) begin
        errors++;
        $display("FAIL burst_beat%0d: got v=%b a=%0d d=%h l=%b want v=1 a=%0d d=%h l=%b",
                 k, outValid, outAddr, outData, outLast, ea, 8'(8'h10 + ea), (k == 7));
      end
      if (busy === 1'b1) busyCycles++;
      step();
    end
    checks++;
    if (busyCycles != 7 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL burst_busy: got busy_cycles=%0d v=%b want 7 and v=0", busyCycles, outValid);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] snap [8];
    logic [7:0] orig0;
    int got, cyc;
    bit stalled;
    logic [2:0] ea;
    for (int i = 0; i < 8; i++) begin
      bankMem[i] = 8'($urandom);
      snap[i] = bankMem[i];
    end
    orig0 = snap[0];
    outReady = 1'b1;
    rdReq = 1'b1; rdBurst = 1'b1; rdAddr = 3'd6;
    step();
    clearReq();
    got = 0; cyc = 0; stalled = 1'b0;
    while (got < 8 && cyc < 60) begin
      cyc++;
      if (outValid === 1'b1) begin
        if (outAddr == 3'd0 && !stalled) begin
          stalled = 1'b1;
          for (int j = 0; j < 3; j++) begin
            outReady = 1'b0;
            bankMem[0] = ~orig0 ^ 8'(j);
            step();
            checks++;
            if ({outValid, outAddr, outData} !== {1'b1, 3'd0, orig0}) begin
              errors++;
              $display("FAIL stall_hold%0d: got v=%b a=%0d d=%h want v=1 a=0 d=%h",
                       j, outValid, outAddr, outData, orig0);
            end
          end
          outReady = 1'b1;
        end
        ea = 3'((6 + got) % 8);
        checks++;
        if ({outAddr, outData, outLast} !== {ea, snap[ea], (got == 7)}) begin
          errors++;
          $display("FAIL stall_beat%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                   got, outAddr, outData, outLast, ea, snap[ea], (got == 7));
        end
        got++;
      end
      step();
    end
    checks++;
    if (got != 8 || outValid !== 1'b0 || !stalled) begin
      errors++;
      $display("FAIL stall_count: got beats=%0d v=%b stalled=%b want 8, v=0, stalled=1", got, outValid, stalled);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [2:0] start;
    for (int i = 0; i < 8; i++) bankMem[i] = 8'($urandom);
    start = 3'($urandom_range(0, 7));
    outReady = 1'b1;
    rdReq = 1'b1; rdBurst = 1'b1; rdAddr = start;
    step();
    clearReq();
    for (int k = 0; k < 4; k++) step();
    checks++;
    if ({outValid, outAddr} !== {1'b1, 3'(start + 3'd4)}) begin
      errors++;
      $display("FAIL midrst_beat4: got v=%b a=%0d want v=1 a=%0d", outValid, outAddr, 3'(start + 3'd4));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({outValid, busy, outData} !== 10'd0) begin
      errors++;
      $display("FAIL midrst_state: got v=%b busy=%b d=%h want 0 0 00", outValid, busy, outData);
    end
    step();
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL midrst_discard: got outValid=%b want 0", outValid);
    end
    rdReq = 1'b1; rdAddr = 3'd1;
    #1;
    checks++;
    if (rdAck !== 1'b1) begin
      errors++; $display("FAIL midrst_ack: got %b want 1", rdAck);
    end
    step();
    clearReq();
    checks++;
    if ({outValid, outAddr, outData, outLast} !== {1'b1, 3'd1, bankMem[1], 1'b1}) begin
      errors++;
      $display("FAIL midrst_single: got v=%b a=%0d d=%h l=%b want v=1 a=1 d=%h l=1",
               outValid, outAddr, outData, outLast, bankMem[1]);
    end
    step();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) bankMem[i] = 8'($urandom);
    outReady = 1'b1;
    rdReq = 1'b1; rdBurst = 1'b1; rdAddr = 3'd0;
    step();
    rdBurst = 1'b0; rdAddr = 3'd4;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (rdAck !== (k == 7)) begin
        errors++; $display("FAIL b2b_ack%0d: got %b want %b", k, rdAck, (k == 7));
      end
      checks++;
      if ({outValid, outAddr, outData, outLast} !== {1'b1, 3'(k), bankMem[k], (k == 7)}) begin
        errors++;
        $display("FAIL b2b_beat%0d: got v=%b a=%0d d=%h l=%b want v=1 a=%0d d=%h l=%b",
                 k, outValid, outAddr, outData, outLast, k, bankMem[k], (k == 7));
      end
      step();
    end
    clearReq();
    checks++;
    if ({outValid, outAddr, outData, outLast} !== {1'b1, 3'd4, bankMem[4], 1'b1}) begin
      errors++;
      $display("FAIL b2b_next: got v=%b a=%0d d=%h l=%b want v=1 a=4 d=%h l=1",
               outValid, outAddr, outData, outLast, bankMem[4]);
    end
    step();
  endtask

  task automatic test_random_single;
    logic [2:0] a, wa;
    logic [7:0] wd, ed;
    bit w;
    outReady = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) bankMem[i] = 8'($urandom);
      a = 3'($urandom); wa = 3'($urandom); wd = 8'($urandom); w = 1'($urandom);
      ed = (w && wa == a) ? wd : bankMem[a];
      rdReq = 1'b1; rdAddr = a; regWrite = w; wrAddr = wa; wrData = wd;
      #1;
      checks++;
      if (rdAck !== 1'b1) begin
        errors++; $display("FAIL rsingle_ack%0d: got %b want 1", n, rdAck);
      end
      step();
      clearReq();
      if (w) bankMem[wa] = wd;
      checks++;
      if ({outValid, outAddr, outData, outLast} !== {1'b1, a, ed, 1'b1}) begin
        errors++;
        $display("FAIL rsingle%0d: got v=%b a=%0d d=%h l=%b want v=1 a=%0d d=%h l=1",
                 n, outValid, outAddr, outData, outLast, a, ed);
      end
      step();
    end
  endtask

  task automatic test_random_bursts;
    logic [2:0] start, ea;
    logic [7:0] snap [8];
    int got, cyc;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) begin
        bankMem[i] = 8'($urandom);
        snap[i] = bankMem[i];
      end
      start = 3'($urandom);
      outReady = 1'b1;
      rdReq = 1'b1; rdBurst = 1'b1; rdAddr = start;
      #1;
      checks++;
      if (rdAck !== 1'b1) begin
        errors++; $display("FAIL rburst_ack%0d: got %b want 1", n, rdAck);
      end
      step();
      clearReq();
      got = 0; cyc = 0;
      while (got < 8 && cyc < 200) begin
        cyc++;
        outReady = 1'($urandom);
        if (outValid === 1'b1 && outReady) begin
          ea = 3'((start + got) % 8);
          checks++;
          if ({outAddr, outData, outLast} !== {ea, snap[ea], (got == 7)}) begin
            errors++;
            $display("FAIL rburst%0d_beat%0d: got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                     n, got, outAddr, outData, outLast, ea, snap[ea], (got == 7));
          end
          got++;
        end
        step();
      end
      outReady = 1'b1;
      checks++;
      if (got != 8 || outValid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rburst%0d_end: got beats=%0d v=%b busy=%b want 8 0 0", n, got, outValid, busy);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_bypass();
    test_burst_wrap();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    test_random_single();
    test_random_bursts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
